// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-wide memory controller.
// Optional build macro MEM_CTRL_IO_STALL_EN is consumed in mem_ctrl.sv.
package mem_ctrl_pkg;

    localparam int ADDR_WID = 32;
    localparam int DATA_WID = 32;

    localparam logic [ADDR_WID-1:0] DEFAULT_IO_BASE = 32'h0003_0000;

    localparam logic [1:0] LS_SIZE_BYTE = 2'd0;
    localparam logic [1:0] LS_SIZE_HALF = 2'd1;
    localparam logic [1:0] LS_SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IF_RD = 2'd1,
        ST_LS_RD = 2'd2,
        ST_LS_WR = 2'd3
    } state_t;

    // Transfer length in bytes; size code 3 behaves as a word.
    function automatic logic [2:0] xfer_len(input logic [1:0] size);
        logic [2:0] len;
        case (size)
            LS_SIZE_BYTE: len = 3'd1;
            LS_SIZE_HALF: len = 3'd2;
            LS_SIZE_WORD: len = 3'd4;
            default:      len = 3'd4;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Fetch / load-store / byte RAM bus bundle between the requesters and mem_ctrl.
// slave = controller side, master = requesters plus RAM.
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic                rdy;
    logic                if_en;
    logic [ADDR_WID-1:0] if_pc;
    logic                if_done;
    logic [DATA_WID-1:0] if_data;
    logic                ls_en;
    logic                ls_wr;
    logic [1:0]          ls_size;
    logic [ADDR_WID-1:0] ls_addr;
    logic [DATA_WID-1:0] ls_wdata;
    logic                ls_done;
    logic [DATA_WID-1:0] ls_rdata;
    logic [7:0]          mem_din;
    logic [7:0]          mem_dout;
    logic [ADDR_WID-1:0] mem_a;
    logic                mem_wr;
    logic                io_buffer_full;

    modport slave (
        input  rdy, if_en, if_pc, ls_en, ls_wr, ls_size, ls_addr, ls_wdata,
               mem_din, io_buffer_full,
        output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );

    modport master (
        output rdy, if_en, if_pc, ls_en, ls_wr, ls_size, ls_addr, ls_wdata,
               mem_din, io_buffer_full,
        input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/mem_ctrl_byte_seq.sv
// Byte sequencer: counter, address generator, last-byte flag, store byte select
// and little-endian read-data assembly.
module mem_ctrl_byte_seq
    import mem_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [ADDR_WID-1:0] addr_i,
    input  logic [2:0]          len_i,
    input  logic [23:0]         wdata_hi_i,
    input  logic                advance_i,
    input  logic                capture_i,
    input  logic [7:0]          din_i,
    output logic                last_o,
    output logic [ADDR_WID-1:0] next_addr_o,
    output logic [7:0]          next_byte_o,
    output logic [DATA_WID-1:0] data_o
);

    logic [ADDR_WID-1:0] base_q;
    logic [2:0]          len_q;
    logic [1:0]          cnt_q;
    logic [23:0]         wdata_q;
    logic [DATA_WID-1:0] data_q;

    assign last_o      = ({1'b0, cnt_q} == (len_q - 3'd1));
    assign next_addr_o = base_q + {30'd0, cnt_q} + 32'd1;

    // Byte 0 of a store is driven straight from the request; only the upper bytes are kept.
    always_comb begin
        next_byte_o = 8'h00;
        case (cnt_q)
            2'd0:    next_byte_o = wdata_q[7:0];
            2'd1:    next_byte_o = wdata_q[15:8];
            2'd2:    next_byte_o = wdata_q[23:16];
            default: next_byte_o = 8'h00;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign data_o[8*gi +: 8] = (cnt_q == gi[1:0]) ? din_i : data_q[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q  <= '0;
            len_q   <= 3'd0;
            cnt_q   <= 2'd0;
            wdata_q <= '0;
            data_q  <= '0;
        end else if (start_i) begin
            base_q  <= addr_i;
            len_q   <= len_i;
            cnt_q   <= 2'd0;
            wdata_q <= wdata_hi_i;
            data_q  <= '0;
        end else if (advance_i) begin
            cnt_q <= cnt_q + 2'd1;
            if (capture_i) begin
                data_q <= data_o;
            end
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates fetch vs load-store, runs the byte-wide RAM FSM.
// Define MEM_CTRL_IO_STALL_EN to make I/O stores honour io_buffer_full.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [ADDR_WID-1:0] IO_BASE = DEFAULT_IO_BASE
) (
    input logic       clk,
    input logic       rst_n,
    mem_ctrl_if.slave bus
);

`ifdef MEM_CTRL_IO_STALL_EN
    localparam bit IO_STALL_EN = 1'b1;
`else
    localparam bit IO_STALL_EN = 1'b0;
`endif

    state_t              state_q;
    logic [ADDR_WID-1:0] mem_a_q;
    logic [7:0]          mem_dout_q;
    logic                mem_wr_q;
    logic                if_done_q;
    logic                ls_done_q;
    logic [DATA_WID-1:0] if_data_q;
    logic [DATA_WID-1:0] ls_rdata_q;
    logic                io_store_q;

    logic                idle_ok;
    logic                ls_is_io;
    logic                ls_blocked;
    logic                accept_ls;
    logic                accept_if;
    logic                stall;
    logic                seq_advance;
    logic                seq_capture;
    logic                seq_last;
    logic [ADDR_WID-1:0] seq_next_addr;
    logic [7:0]          seq_next_byte;
    logic [DATA_WID-1:0] seq_data;

    // The done-outputs-low term enforces a one-cycle gap after every completion.
    assign idle_ok    = (state_q == ST_IDLE) && bus.rdy && !if_done_q && !ls_done_q;
    assign ls_is_io   = (bus.ls_addr >= IO_BASE);
    assign ls_blocked = IO_STALL_EN && bus.ls_wr && ls_is_io && bus.io_buffer_full;
    assign accept_ls  = idle_ok && bus.ls_en && !ls_blocked;
    assign accept_if  = idle_ok && bus.if_en && !accept_ls;
    assign stall      = IO_STALL_EN && io_store_q && bus.io_buffer_full;

    always_comb begin
        seq_advance = 1'b0;
        seq_capture = 1'b0;
        case (state_q)
            ST_IF_RD: begin
                seq_advance = bus.if_en;
                seq_capture = 1'b1;
            end
            ST_LS_RD: begin
                seq_advance = 1'b1;
                seq_capture = 1'b1;
            end
            ST_LS_WR: seq_advance = mem_wr_q && !seq_last;
            default:  seq_advance = 1'b0;
        endcase
    end

    mem_ctrl_byte_seq u_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (accept_ls || accept_if),
        .addr_i      (accept_ls ? bus.ls_addr : bus.if_pc),
        .len_i       (accept_ls ? xfer_len(bus.ls_size) : 3'd4),
        .wdata_hi_i  (bus.ls_wdata[31:8]),
        .advance_i   (seq_advance),
        .capture_i   (seq_capture),
        .din_i       (bus.mem_din),
        .last_o      (seq_last),
        .next_addr_o (seq_next_addr),
        .next_byte_o (seq_next_byte),
        .data_o      (seq_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mem_a_q    <= '0;
            mem_dout_q <= 8'h00;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
            io_store_q <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_ls) begin
                        mem_a_q    <= bus.ls_addr;
                        io_store_q <= bus.ls_wr && ls_is_io;
                        if (bus.ls_wr) begin
                            state_q    <= ST_LS_WR;
                            mem_wr_q   <= 1'b1;
                            mem_dout_q <= bus.ls_wdata[7:0];
                        end else begin
                            state_q <= ST_LS_RD;
                        end
                    end else if (accept_if) begin
                        mem_a_q <= bus.if_pc;
                        state_q <= ST_IF_RD;
                    end
                end
                ST_IF_RD: begin
                    if (!bus.if_en) begin
                        state_q <= ST_IDLE;
                    end else begin
                        mem_a_q <= seq_next_addr;
                        if (seq_last) begin
                            if_data_q <= seq_data;
                            if_done_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end
                    end
                end
                ST_LS_RD: begin
                    mem_a_q <= seq_next_addr;
                    if (seq_last) begin
                        ls_rdata_q <= seq_data;
                        ls_done_q  <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_LS_WR: begin
                    // mem_wr_q low means the current byte was stalled and is still pending.
                    if (mem_wr_q && seq_last) begin
                        mem_wr_q  <= 1'b0;
                        ls_done_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        if (mem_wr_q) begin
                            mem_a_q    <= seq_next_addr;
                            mem_dout_q <= seq_next_byte;
                        end
                        mem_wr_q <= !stall;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_a    = mem_a_q;
    assign bus.mem_dout = mem_dout_q;
    assign bus.mem_wr   = mem_wr_q;
    assign bus.if_done  = if_done_q;
    assign bus.if_data  = if_data_q;
    assign bus.ls_done  = ls_done_q;
    assign bus.ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: RAM model on the byte bus, one task per scenario.
// Scenario test_io_stall changes with MEM_CTRL_IO_STALL_EN.
module tb_mem_ctrl;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    logic [7:0] ram [0:65535];

    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous-read RAM: mem_din reflects mem_a for the capture on the next edge.
    assign bus.mem_din = ram[bus.mem_a[15:0]];
    always @(posedge clk) begin
        if (bus.mem_wr === 1'b1) ram[bus.mem_a[15:0]] <= bus.mem_dout;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        n_cmp++; if (bus.if_done !== 1'b0) begin n_fail++; $display("FAIL reset_if_done: got %b expected 0", bus.if_done); end
        n_cmp++; if (bus.ls_done !== 1'b0) begin n_fail++; $display("FAIL reset_ls_done: got %b expected 0", bus.ls_done); end
        n_cmp++; if (bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr: got %b expected 0", bus.mem_wr); end
        n_cmp++; if (bus.mem_a !== 32'h0) begin n_fail++; $display("FAIL reset_mem_a: got %h expected 0", bus.mem_a); end
        n_cmp++; if (bus.mem_dout !== 8'h0) begin n_fail++; $display("FAIL reset_mem_dout: got %h expected 0", bus.mem_dout); end
        n_cmp++; if (bus.if_data !== 32'h0) begin n_fail++; $display("FAIL reset_if_data: got %h expected 0", bus.if_data); end
        n_cmp++; if (bus.ls_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_ls_rdata: got %h expected 0", bus.ls_rdata); end
        rst_n = 1'b1;
        step();
        $display("reset: released");
    endtask

    task automatic test_if_read();
        bus.if_en = 1'b1;
        bus.if_pc = 32'h0000_0100;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (bus.mem_a !== 32'h100 + i) begin n_fail++; $display("FAIL if_read_addr%0d: got %h expected %h", i, bus.mem_a, 32'h100 + i); end
            n_cmp++; if (bus.if_done !== 1'b0) begin n_fail++; $display("FAIL if_read_early_done%0d: got %b expected 0", i, bus.if_done); end
        end
        step();
        n_cmp++; if (bus.if_done !== 1'b1) begin n_fail++; $display("FAIL if_read_done: got %b expected 1", bus.if_done); end
        n_cmp++; if (bus.if_data !== 32'h4433_2211) begin n_fail++; $display("FAIL if_read_data: got %h expected 44332211", bus.if_data); end
        bus.if_en = 1'b0;
        step();
        n_cmp++; if (bus.if_done !== 1'b0) begin n_fail++; $display("FAIL if_read_done_pulse: got %b expected 0", bus.if_done); end
        $display("if_read: pc=00000100 data=%h", bus.if_data);
    endtask

    task automatic test_arbitration();
        bus.if_en   = 1'b1;
        bus.if_pc   = 32'h0000_0200;
        bus.ls_en   = 1'b1;
        bus.ls_wr   = 1'b0;
        bus.ls_size = 2'd0;
        bus.ls_addr = 32'h0000_2001;
        step();
        n_cmp++; if (bus.mem_a !== 32'h2001) begin n_fail++; $display("FAIL arb_ls_first_addr: got %h expected 00002001", bus.mem_a); end
        step();
        n_cmp++; if (bus.ls_done !== 1'b1) begin n_fail++; $display("FAIL arb_ls_done: got %b expected 1", bus.ls_done); end
        n_cmp++; if (bus.ls_rdata !== 32'h0000_00F0) begin n_fail++; $display("FAIL arb_ls_rdata: got %h expected 000000f0", bus.ls_rdata); end
        n_cmp++; if (bus.if_done !== 1'b0) begin n_fail++; $display("FAIL arb_if_not_done: got %b expected 0", bus.if_done); end
        bus.ls_en = 1'b0;
        step();
        n_cmp++; if (bus.ls_done !== 1'b0) begin n_fail++; $display("FAIL arb_gap_ls_done: got %b expected 0", bus.ls_done); end
        step();
        n_cmp++; if (bus.mem_a !== 32'h200) begin n_fail++; $display("FAIL arb_if_after_gap_addr: got %h expected 00000200", bus.mem_a); end
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if (bus.if_done !== 1'b1) begin n_fail++; $display("FAIL arb_if_done: got %b expected 1", bus.if_done); end
        n_cmp++; if (bus.if_data !== 32'hD4C3_B2A1) begin n_fail++; $display("FAIL arb_if_data: got %h expected d4c3b2a1", bus.if_data); end
        bus.if_en = 1'b0;
        step();
        $display("arbitration: ls=%h if=%h", bus.ls_rdata, bus.if_data);
    endtask

    task automatic test_store_half();
        bus.ls_en    = 1'b1;
        bus.ls_wr    = 1'b1;
        bus.ls_size  = 2'd1;
        bus.ls_addr  = 32'h0000_1FFF;
        bus.ls_wdata = 32'h1234_BEEF;
        step();
        n_cmp++; if ({bus.mem_wr, bus.mem_a, bus.mem_dout} !== {1'b1, 32'h1FFF, 8'hEF}) begin n_fail++; $display("FAIL store_half_b0: got wr=%b a=%h d=%h expected wr=1 a=00001fff d=ef", bus.mem_wr, bus.mem_a, bus.mem_dout); end
        step();
        n_cmp++; if ({bus.mem_wr, bus.mem_a, bus.mem_dout} !== {1'b1, 32'h2000, 8'hBE}) begin n_fail++; $display("FAIL store_half_b1: got wr=%b a=%h d=%h expected wr=1 a=00002000 d=be", bus.mem_wr, bus.mem_a, bus.mem_dout); end
        step();
        n_cmp++; if (bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL store_half_wr_off: got %b expected 0", bus.mem_wr); end
        n_cmp++; if (bus.ls_done !== 1'b1) begin n_fail++; $display("FAIL store_half_done: got %b expected 1", bus.ls_done); end
        bus.ls_en = 1'b0;
        step();
        n_cmp++; if (bus.ls_done !== 1'b0 || bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL store_half_after: got done=%b wr=%b expected 0 0", bus.ls_done, bus.mem_wr); end
        n_cmp++; if ({ram[16'h1FFF], ram[16'h2000], ram[16'h2001]} !== {8'hEF, 8'hBE, 8'hF0}) begin n_fail++; $display("FAIL store_half_ram: got %h %h %h expected ef be f0", ram[16'h1FFF], ram[16'h2000], ram[16'h2001]); end
        $display("store_half: 1fff=%h 2000=%h", ram[16'h1FFF], ram[16'h2000]);
    endtask

    task automatic test_abort();
        bus.if_en = 1'b1;
        bus.if_pc = 32'h0000_0100;
        step();
        step();
        step();
        bus.if_en = 1'b0;
        step();
        n_cmp++; if (bus.if_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b expected 0", bus.if_done); end
        step();
        n_cmp++; if (bus.if_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done_late: got %b expected 0", bus.if_done); end
        bus.if_en = 1'b1;
        bus.if_pc = 32'h0000_0200;
        step();
        n_cmp++; if (bus.mem_a !== 32'h200) begin n_fail++; $display("FAIL abort_restart_addr: got %h expected 00000200", bus.mem_a); end
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if (bus.if_done !== 1'b1) begin n_fail++; $display("FAIL abort_restart_done: got %b expected 1", bus.if_done); end
        n_cmp++; if (bus.if_data !== 32'hD4C3_B2A1) begin n_fail++; $display("FAIL abort_restart_data: got %h expected d4c3b2a1", bus.if_data); end
        bus.if_en = 1'b0;
        step();
        $display("abort: restart data=%h", bus.if_data);
    endtask

    task automatic test_reset_mid_store();
        bus.ls_en    = 1'b1;
        bus.ls_wr    = 1'b1;
        bus.ls_size  = 2'd2;
        bus.ls_addr  = 32'h0000_3000;
        bus.ls_wdata = 32'hCAFE_F00D;
        step();
        step();
        n_cmp++; if (bus.mem_wr !== 1'b1) begin n_fail++; $display("FAIL rst_store_active: got %b expected 1", bus.mem_wr); end
        #2;
        rst_n    = 1'b0;
        bus.ls_en = 1'b0;
        #1;
        n_cmp++; if (bus.mem_wr !== 1'b0 || bus.mem_a !== 32'h0) begin n_fail++; $display("FAIL rst_async: got wr=%b a=%h expected 0 00000000", bus.mem_wr, bus.mem_a); end
        step();
        rst_n = 1'b1;
        n_cmp++; if ({ram[16'h3000], ram[16'h3001]} !== {8'h0D, 8'h00}) begin n_fail++; $display("FAIL rst_store_ram: got %h %h expected 0d 00", ram[16'h3000], ram[16'h3001]); end
        bus.ls_en   = 1'b1;
        bus.ls_wr   = 1'b0;
        bus.ls_size = 2'd2;
        bus.ls_addr = 32'hFFFF_FFFE;
        step();
        n_cmp++; if (bus.mem_a !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL wrap_addr0: got %h expected fffffffe", bus.mem_a); end
        step();
        n_cmp++; if (bus.mem_a !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_addr1: got %h expected ffffffff", bus.mem_a); end
        step();
        n_cmp++; if (bus.mem_a !== 32'h0) begin n_fail++; $display("FAIL wrap_addr2: got %h expected 00000000", bus.mem_a); end
        step();
        n_cmp++; if (bus.mem_a !== 32'h1) begin n_fail++; $display("FAIL wrap_addr3: got %h expected 00000001", bus.mem_a); end
        step();
        n_cmp++; if (bus.ls_done !== 1'b1) begin n_fail++; $display("FAIL wrap_done: got %b expected 1", bus.ls_done); end
        n_cmp++; if (bus.ls_rdata !== 32'h8D7C_6B5A) begin n_fail++; $display("FAIL wrap_rdata: got %h expected 8d7c6b5a", bus.ls_rdata); end
        bus.ls_en = 1'b0;
        step();
        $display("reset_mid_store: wrap load=%h", bus.ls_rdata);
    endtask

    task automatic test_rdy();
        bus.rdy   = 1'b0;
        bus.if_en = 1'b1;
        bus.if_pc = 32'h0000_0100;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (bus.mem_a === 32'h100) begin n_fail++; $display("FAIL rdy_block%0d: got a=%h expected no accept", i, bus.mem_a); end
        end
        bus.rdy = 1'b1;
        step();
        n_cmp++; if (bus.mem_a !== 32'h100) begin n_fail++; $display("FAIL rdy_accept: got %h expected 00000100", bus.mem_a); end
        bus.rdy = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if (bus.if_done !== 1'b1 || bus.if_data !== 32'h4433_2211) begin n_fail++; $display("FAIL rdy_inflight: got done=%b data=%h expected 1 44332211", bus.if_done, bus.if_data); end
        bus.if_en = 1'b0;
        bus.rdy   = 1'b1;
        step();
        $display("rdy: inflight data=%h", bus.if_data);
    endtask

    task automatic test_back_to_back();
        bus.ls_en    = 1'b1;
        bus.ls_wr    = 1'b1;
        bus.ls_size  = 2'd2;
        bus.ls_addr  = 32'h0000_4000;
        bus.ls_wdata = 32'hCAFE_F00D;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if ({bus.mem_wr, bus.mem_a} !== {1'b1, 32'h4000 + i}) begin n_fail++; $display("FAIL b2b_store_b%0d: got wr=%b a=%h expected 1 %h", i, bus.mem_wr, bus.mem_a, 32'h4000 + i); end
        end
        step();
        n_cmp++; if (bus.ls_done !== 1'b1) begin n_fail++; $display("FAIL b2b_store_done: got %b expected 1", bus.ls_done); end
        bus.ls_wr   = 1'b0;
        bus.ls_size = 2'd3;
        step();
        n_cmp++; if (bus.ls_done !== 1'b0 || bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got done=%b wr=%b expected 0 0", bus.ls_done, bus.mem_wr); end
        step();
        n_cmp++; if (bus.mem_a !== 32'h4000) begin n_fail++; $display("FAIL b2b_load_addr: got %h expected 00004000", bus.mem_a); end
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if (bus.ls_done !== 1'b1 || bus.ls_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL b2b_load_word: got done=%b data=%h expected 1 cafef00d", bus.ls_done, bus.ls_rdata); end
        bus.ls_size = 2'd1;
        bus.ls_addr = 32'h0000_4002;
        step();
        step();
        step();
        step();
        n_cmp++; if (bus.ls_done !== 1'b1 || bus.ls_rdata !== 32'h0000_CAFE) begin n_fail++; $display("FAIL b2b_load_half: got done=%b data=%h expected 1 0000cafe", bus.ls_done, bus.ls_rdata); end
        bus.ls_en = 1'b0;
        step();
        $display("back_to_back: word=cafef00d half=%h", bus.ls_rdata);
    endtask

    task automatic test_io_stall();
        bus.io_buffer_full = 1'b1;
        bus.ls_en    = 1'b1;
        bus.ls_wr    = 1'b1;
        bus.ls_size  = 2'd0;
        bus.ls_addr  = 32'h0003_0000;
        bus.ls_wdata = 32'h0000_0077;
`ifdef MEM_CTRL_IO_STALL_EN
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++; if (bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL io_stall_hold%0d: got %b expected 0", i, bus.mem_wr); end
        end
        bus.io_buffer_full = 1'b0;
`endif
        step();
        n_cmp++; if ({bus.mem_wr, bus.mem_a, bus.mem_dout} !== {1'b1, 32'h3_0000, 8'h77}) begin n_fail++; $display("FAIL io_store_write: got wr=%b a=%h d=%h expected 1 00030000 77", bus.mem_wr, bus.mem_a, bus.mem_dout); end
        step();
        n_cmp++; if (bus.ls_done !== 1'b1 || bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL io_store_done: got done=%b wr=%b expected 1 0", bus.ls_done, bus.mem_wr); end
        bus.ls_en          = 1'b0;
        bus.io_buffer_full = 1'b0;
        step();
        $display("io_stall: store to 00030000 written");
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
        ram[16'h0100] <= 8'h11; ram[16'h0101] <= 8'h22; ram[16'h0102] <= 8'h33; ram[16'h0103] <= 8'h44;
        ram[16'h0200] <= 8'hA1; ram[16'h0201] <= 8'hB2; ram[16'h0202] <= 8'hC3; ram[16'h0203] <= 8'hD4;
        ram[16'h2001] <= 8'hF0;
        ram[16'hFFFE] <= 8'h5A; ram[16'hFFFF] <= 8'h6B; ram[16'h0000] <= 8'h7C; ram[16'h0001] <= 8'h8D;
        n_cmp  = 0;
        n_fail = 0;
        rst_n              = 1'b0;
        bus.rdy            = 1'b1;
        bus.if_en          = 1'b0;
        bus.if_pc          = '0;
        bus.ls_en          = 1'b0;
        bus.ls_wr          = 1'b0;
        bus.ls_size        = 2'd0;
        bus.ls_addr        = '0;
        bus.ls_wdata       = '0;
        bus.io_buffer_full = 1'b0;
        test_reset();
        test_if_read();
        test_arbitration();
        test_store_half();
        test_abort();
        test_reset_mid_store();
        test_rdy();
        test_back_to_back();
        test_io_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
